spi_reg_bank: RTL and testbench
===============================

# spi_reg_bank

Register bank and frame-commit stage that sits directly downstream of the SPI slave shift register inside the decoder IP. It runs on the fabric clock and synchronises the SPI chip select. When a frame ends it captures the slave's parallel outputs, validates them and commits writes into a bank of 32-bit registers. It also drives the read-data word the slave loads into its shift buffer for read frames, and maintains frame and error counters.

## Interface
- SPI_DATA_WIDTH, 32, data field width
- SPI_ADDR_WIDTH, 8, address field width
- SPI_CTRL_WIDTH, 8, control field width
- NUM_REGS, 16, number of R/W registers, addresses 0..NUM_REGS-1 (≤ 2^SPI_ADDR_WIDTH-1)
- STATUS_ADDR, 8'hFF, address of status word
- sys_clk  in  1  fabric clock, all logic on posedge
- reset  in  1  asynchronous, active-high reset
- spi_cs_n  in  1  raw SPI chip select (asynchronous to sys_clk)
- spi_ctrl  in  SPI_CTRL_WIDTH  control byte of last frame (upper byte of slave buffer)
- spi_address  in  SPI_ADDR_WIDTH  slave address output
- spi_out_data  in  SPI_DATA_WIDTH  slave data output
- spi_shft_cnt  in  6  slave shift counter (debug count output)
- spi_in_data  out  SPI_DATA_WIDTH  read word to slave, combinational from spi_address
- reg_bus  out  NUM_REGS*SPI_DATA_WIDTH  all registers, reg i at [i*32 +: 32]
- wr_strobe  out  NUM_REGS  one-cycle pulse per committed register write
- frame_count  out  16  accepted frames, wraps mod 2^16
- err_count  out  8  rejected frames, saturates at 255
- busy  out  1  high in CAPTURE and COMMIT

## Operation
- spi_cs_n passes through a 2-FF synchroniser; both FFs reset to 1.
- States:
  - IDLE: go to ACTIVE when synced cs_n = 0.
  - ACTIVE: on synced cs_n = 1, go to CAPTURE and latch spi_ctrl, spi_address, spi_out_data and spi_shft_cnt into capture registers on the same edge.
  - CAPTURE: validate the latched values, then go to COMMIT.
  - COMMIT: apply the result, then go to IDLE.
- Validation. Frame is rejected (err_count++, no write, frame_count unchanged) if any of the following hold:
  - shft_cnt ≠ 0 (incomplete frame);
  - ctrl[7:1] ≠ 0;
  - the frame is a write to an address ≥ NUM_REGS other than STATUS_ADDR.
- ctrl[0] = 1 marks a read frame. Accepted read: frame_count++ only.
- ctrl[0] = 0 marks a write frame. Accepted write:
  - reg[addr] <= data;
  - wr_strobe[addr] = 1 for one cycle;
  - frame_count++.
- Write to STATUS_ADDR: clears err_count; frame_count++; no strobe.
- spi_in_data:
  - spi_address < NUM_REGS: reg[spi_address];
  - spi_address = STATUS_ADDR: {frame_count, 8'h00, err_count};
  - any other address: 0.
- Registers and counters change only in COMMIT, which occurs after cs_n deasserts, so spi_in_data is stable during a frame.
- A new cs_n falling edge during CAPTURE or COMMIT does not disturb the commit, because it uses only the capture registers. The FSM enters ACTIVE from IDLE on the next cycle.

## Timing
- Reset values: all registers 0, reg_bus 0, wr_strobe 0, frame_count 0, err_count 0, busy 0, state IDLE, capture registers 0.
- Raw cs_n rise → synced high after 2 sys_clk edges. Capture happens on the 3rd edge, and the COMMIT update on the 4th edge (±1 edge due to synchroniser phase).
- reg_bus, the counters and wr_strobe become visible after the COMMIT edge. wr_strobe drops on the next edge.
- busy is high for exactly 2 cycles per frame.
- Required minimum cs_n high time: 5 sys_clk.
- Required minimum cs_n low time: 3 sys_clk. Shorter pulses may be missed; a missed pulse is not an error.
- Reset asserted mid-frame or mid-commit clears everything immediately, and no commit occurs. Because the synchroniser resets to 1, releasing reset while cs_n is high produces no spurious frame. Releasing reset while cs_n is low enters ACTIVE, and that frame is committed normally at its end.
- err_count at 255 stays 255. frame_count 16'hFFFF + 1 → 0.

## Test plan
- Write frame: ctrl 0x00, addr 3, data 0xA5A51234, shft_cnt 0 → reg3 = 0xA5A51234, wr_strobe = 16'h0008 for 1 cycle, frame_count = 1, busy high 2 cycles.
- Read frame: ctrl 0x01, spi_address 3 → spi_in_data = 0xA5A51234 combinationally; no strobe; frame_count +1; registers unchanged.
- Rejections:
  - write to addr 0x20 → err_count = 1;
  - shft_cnt = 20 → err_count = 2;
  - ctrl 0x80 → err_count = 3.
  - In all three cases: no register change, no strobe, frame_count unchanged.
- Status:
  - spi_address 0xFF after the rejection scenario → spi_in_data = {frame_count, 8'h00, 8'h03};
  - write frame to 0xFF → err_count = 0, frame_count +1.
- 260 rejected frames → err_count saturates at 255. cs_n low pulse of 1 sys_clk → no state change.
- Reset asserted while in ACTIVE with a valid write pending → reg_bus 0, counters 0. After release with cs_n high: no commit and no strobe.

Source files
------------

// File: rtl/spi_reg_bank.sv
// Frame-commit stage behind the SPI slave shift register: synchronises cs_n, captures
// the slave's parallel outputs at frame end, validates them and commits into a register bank.
module spi_reg_bank #(
    parameter int                          SPI_DATA_WIDTH = 32,
    parameter int                          SPI_ADDR_WIDTH = 8,
    parameter int                          SPI_CTRL_WIDTH = 8,
    parameter int                          NUM_REGS       = 16,
    parameter logic [SPI_ADDR_WIDTH-1:0]   STATUS_ADDR    = 8'hFF
) (
    input  logic                                  sys_clk,
    input  logic                                  reset,
    input  logic                                  spi_cs_n,
    input  logic [SPI_CTRL_WIDTH-1:0]             spi_ctrl,
    input  logic [SPI_ADDR_WIDTH-1:0]             spi_address,
    input  logic [SPI_DATA_WIDTH-1:0]             spi_out_data,
    input  logic [5:0]                            spi_shft_cnt,
    output logic [SPI_DATA_WIDTH-1:0]             spi_in_data,
    output logic [NUM_REGS*SPI_DATA_WIDTH-1:0]    reg_bus,
    output logic [NUM_REGS-1:0]                   wr_strobe,
    output logic [15:0]                           frame_count,
    output logic [7:0]                            err_count,
    output logic                                  busy
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [SPI_ADDR_WIDTH-1:0] NUM_REGS_A = SPI_ADDR_WIDTH'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_CAPTURE,
        S_COMMIT
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic r_csMeta;
    logic r_csSync;

    logic [SPI_CTRL_WIDTH-1:0] r_capCtrl;
    logic [SPI_ADDR_WIDTH-1:0] r_capAddr;
    logic [SPI_DATA_WIDTH-1:0] r_capData;
    logic [5:0]                r_capShft;

    logic [SPI_DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]       r_wrStrobe;
    logic [15:0]               r_frameCount;
    logic [7:0]                r_errCount;

    logic             w_isRead;
    logic             w_ctrlOk;
    logic             w_addrInRange;
    logic             w_isStatus;
    logic             w_accept;
    logic [IDX_W-1:0] w_capIdx;

    // Both stages reset high so leaving reset with cs_n idle never looks like a frame start.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_csMeta <= 1'b1;
            r_csSync <= 1'b1;
        end else begin
            r_csMeta <= spi_cs_n;
            r_csSync <= r_csMeta;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        case (r_state)
            S_IDLE:    if (!r_csSync) w_nextState = S_ACTIVE;
            S_ACTIVE:  if (r_csSync) w_nextState = S_CAPTURE;
            S_CAPTURE: begin
                busy        = 1'b1;
                w_nextState = S_COMMIT;
            end
            S_COMMIT:  begin
                busy        = 1'b1;
                w_nextState = S_IDLE;
            end
            default:   w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_capCtrl <= '0;
            r_capAddr <= '0;
            r_capData <= '0;
            r_capShft <= '0;
        end else if (r_state == S_ACTIVE && r_csSync) begin
            r_capCtrl <= spi_ctrl;
            r_capAddr <= spi_address;
            r_capData <= spi_out_data;
            r_capShft <= spi_shft_cnt;
        end
    end

    assign w_isRead      = r_capCtrl[0];
    assign w_ctrlOk      = (r_capCtrl[SPI_CTRL_WIDTH-1:1] == '0);
    assign w_addrInRange = (r_capAddr < NUM_REGS_A);
    assign w_isStatus    = (r_capAddr == STATUS_ADDR);
    assign w_capIdx      = r_capAddr[IDX_W-1:0];
    assign w_accept      = (r_capShft == 6'd0) && w_ctrlOk &&
                           (w_isRead || w_addrInRange || w_isStatus);

    // The result is applied on the edge leaving CAPTURE, so the strobe and counters are visible for the whole COMMIT cycle.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wrStrobe   <= '0;
            r_frameCount <= '0;
            r_errCount   <= '0;
        end else begin
            r_wrStrobe <= '0;
            if (r_state == S_CAPTURE) begin
                if (w_accept) begin
                    r_frameCount <= r_frameCount + 16'd1;
                    if (!w_isRead) begin
                        if (w_isStatus) begin
                            r_errCount <= '0;
                        end else begin
                            r_regs[w_capIdx] <= r_capData;
                            r_wrStrobe       <= NUM_REGS'(1) << w_capIdx;
                        end
                    end
                end else if (r_errCount != 8'hFF) begin
                    r_errCount <= r_errCount + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regBus
        assign reg_bus[g*SPI_DATA_WIDTH +: SPI_DATA_WIDTH] = r_regs[g];
    end

    assign wr_strobe   = r_wrStrobe;
    assign frame_count = r_frameCount;
    assign err_count   = r_errCount;

    always_comb begin
        spi_in_data = '0;
        if (spi_address < NUM_REGS_A) begin
            spi_in_data = r_regs[spi_address[IDX_W-1:0]];
        end else if (spi_address == STATUS_ADDR) begin
            spi_in_data = SPI_DATA_WIDTH'({r_frameCount, 8'h00, r_errCount});
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed plus randomised frames against a behavioural model of the register bank;
// every comparison is an immediate assertion that counts and reports failures.
module tb_spi_reg_bank;

    localparam int NREG   = 16;
    localparam int PERIOD = 10;

    logic         sys_clk = 1'b0;
    logic         reset;
    logic         spi_cs_n;
    logic [7:0]   spi_ctrl;
    logic [7:0]   spi_address;
    logic [31:0]  spi_out_data;
    logic [5:0]   spi_shft_cnt;
    logic [31:0]  spi_in_data;
    logic [NREG*32-1:0] reg_bus;
    logic [NREG-1:0]    wr_strobe;
    logic [15:0]  frame_count;
    logic [7:0]   err_count;
    logic         busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] mRegs [NREG];
    int          mFrame;
    int          mErr;

    spi_reg_bank dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .spi_cs_n     (spi_cs_n),
        .spi_ctrl     (spi_ctrl),
        .spi_address  (spi_address),
        .spi_out_data (spi_out_data),
        .spi_shft_cnt (spi_shft_cnt),
        .spi_in_data  (spi_in_data),
        .reg_bus      (reg_bus),
        .wr_strobe    (wr_strobe),
        .frame_count  (frame_count),
        .err_count    (err_count),
        .busy         (busy)
    );

    always #(PERIOD/2) sys_clk = ~sys_clk;

    initial begin
        #(2_000_000);
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NREG; i++) mRegs[i] = '0;
        mFrame = 0;
        mErr   = 0;
    endtask

    function automatic logic [31:0] modelRead(input logic [7:0] a);
        logic [15:0] f;
        logic [7:0]  e;
        f = mFrame[15:0];
        e = mErr[7:0];
        if (a < NREG)       return mRegs[a[3:0]];
        else if (a == 8'hFF) return {f, 8'h00, e};
        else                 return 32'h0;
    endfunction

    // Applies one frame to the model and returns the strobe the frame should produce.
    task automatic modelFrame(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d,
                              input logic [5:0] s, output logic [15:0] expStrobe);
        bit accept;
        expStrobe = '0;
        accept = (s == 0) && (c[7:1] == 0) && (c[0] || a < NREG || a == 8'hFF);
        if (!accept) begin
            if (mErr < 255) mErr++;
        end else begin
            mFrame = (mFrame + 1) % 65536;
            if (!c[0]) begin
                if (a == 8'hFF) begin
                    mErr = 0;
                end else begin
                    mRegs[a[3:0]] = d;
                    expStrobe = 16'h1 << a[3:0];
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int i = 0; i < NREG; i++) begin
            check($sformatf("%s_reg%0d", tag, i), reg_bus[i*32 +: 32], mRegs[i]);
        end
        check({tag, "_frame"}, {16'h0, frame_count}, mFrame);
        check({tag, "_err"}, {24'h0, err_count}, mErr);
    endtask

    task automatic applyStimulus(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d,
                                 input logic [5:0] s, input string tag);
        bit          seen;
        int          busyCyc;
        int          strobeCyc;
        logic [15:0] strobeOr;
        logic [15:0] expStrobe;
        @(negedge sys_clk);
        spi_ctrl     = c;
        spi_address  = a;
        spi_out_data = d;
        spi_shft_cnt = s;
        spi_cs_n     = 1'b0;
        repeat (4) @(negedge sys_clk);
        spi_cs_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge sys_clk);
            if (busy) seen = 1;
        end
        busyCyc   = 0;
        strobeCyc = 0;
        strobeOr  = '0;
        while (seen && busy && busyCyc < 10) begin
            busyCyc++;
            strobeOr |= wr_strobe;
            if (wr_strobe != 0) strobeCyc++;
            @(negedge sys_clk);
        end
        modelFrame(c, a, d, s, expStrobe);
        check({tag, "_busy_seen"}, {31'h0, seen}, 32'h1);
        check({tag, "_busy_cycles"}, busyCyc, 32'd2);
        check({tag, "_strobe"}, {16'h0, strobeOr}, {16'h0, expStrobe});
        check({tag, "_strobe_cycles"}, strobeCyc, (expStrobe != 0) ? 32'd1 : 32'd0);
        check({tag, "_strobe_after"}, {16'h0, wr_strobe}, 32'h0);
        checkOutput(tag);
        #1;
        check({tag, "_in_data"}, spi_in_data, modelRead(a));
        repeat (4) @(negedge sys_clk);
    endtask

    initial begin
        logic [7:0]  rc;
        logic [7:0]  ra;
        logic [31:0] rd;
        logic [5:0]  rs;
        bit          sawBusy;
        logic [15:0] sawStrobe;

        reset        = 1'b1;
        spi_cs_n     = 1'b1;
        spi_ctrl     = '0;
        spi_address  = '0;
        spi_out_data = '0;
        spi_shft_cnt = '0;
        modelReset();
        #1;
        checkOutput("reset");
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_strobe", {16'h0, wr_strobe}, 32'h0);
        check("reset_in_data", spi_in_data, 32'h0);
        repeat (3) @(negedge sys_clk);
        reset = 1'b0;
        repeat (3) @(negedge sys_clk);

        applyStimulus(8'h00, 8'd3, 32'hA5A51234, 6'd0, "wr3");
        check("wr3_const", reg_bus[3*32 +: 32], 32'hA5A51234);
        applyStimulus(8'h01, 8'd3, 32'h0BAD0BAD, 6'd0, "rd3");
        check("rd3_const", spi_in_data, 32'hA5A51234);

        applyStimulus(8'h00, 8'h20, 32'h11111111, 6'd0, "rej_addr");
        applyStimulus(8'h00, 8'd4, 32'h22222222, 6'd20, "rej_shft");
        applyStimulus(8'h80, 8'd5, 32'h33333333, 6'd0, "rej_ctrl");
        check("rej_err_const", {24'h0, err_count}, 32'd3);

        spi_address = 8'hFF;
        #1;
        check("status_read", spi_in_data, 32'h0002_0003);
        applyStimulus(8'h00, 8'hFF, 32'hDEADBEEF, 6'd0, "status_wr");
        check("status_wr_err_const", {24'h0, err_count}, 32'd0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: rc = 8'h00;
                5, 6, 7:       rc = 8'h01;
                8:             rc = 8'h80 | 8'($urandom);
                default:       rc = 8'($urandom);
            endcase
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: ra = 8'($urandom_range(0, 15));
                7:                   ra = 8'hFF;
                default:             ra = 8'($urandom_range(16, 254));
            endcase
            rd = $urandom;
            rs = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            applyStimulus(rc, ra, rd, rs, $sformatf("rnd%0d", n));
        end

        // A low pulse that falls between two sampling edges never reaches the synchroniser.
        @(posedge sys_clk);
        #1 spi_cs_n = 1'b0;
        #(PERIOD - 2) spi_cs_n = 1'b1;
        sawBusy = 0;
        repeat (10) begin
            @(negedge sys_clk);
            sawBusy |= busy;
        end
        check("glitch_busy", {31'h0, sawBusy}, 32'h0);
        checkOutput("glitch");

        for (int n = 0; n < 260; n++) begin
            applyStimulus(8'h00, 8'd2, $urandom, 6'd20, "sat");
        end
        check("sat_err_const", {24'h0, err_count}, 32'd255);

        // Reset while ACTIVE with a valid write pending must drop the frame entirely.
        @(negedge sys_clk);
        spi_ctrl     = 8'h00;
        spi_address  = 8'd5;
        spi_out_data = 32'hCAFEF00D;
        spi_shft_cnt = 6'd0;
        spi_cs_n     = 1'b0;
        repeat (4) @(negedge sys_clk);
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("rst_mid");
        check("rst_mid_busy", {31'h0, busy}, 32'h0);
        spi_cs_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;
        sawBusy   = 0;
        sawStrobe = '0;
        repeat (12) begin
            @(negedge sys_clk);
            sawBusy   |= busy;
            sawStrobe |= wr_strobe;
        end
        check("rst_rel_busy", {31'h0, sawBusy}, 32'h0);
        check("rst_rel_strobe", {16'h0, sawStrobe}, 32'h0);
        checkOutput("rst_rel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
